// File: rtl/weight_update_pkg.sv
// weight_update_pkg: shared Q6.10 constants, FSM state type and a range helper for the weight update stage.
package weight_update_pkg;
  localparam int FRAC_BITS = 10;
  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;
  typedef enum logic [1:0] {IDLE, LOAD_ERR, UPDATE, DONE} state_t;
  function automatic logic below(input logic [1:0] a, input int n);
    return int'(a) < n;
  endfunction
endpackage

// File: rtl/weight_update_fx_mac_sat.sv
// weight_update_fx_mac_sat: w - ((err*act) >>> SHIFT) saturated to Q6.10, purely combinational.
module weight_update_fx_mac_sat
  import weight_update_pkg::*;
#(
  parameter int SHIFT = FRAC_BITS + 2
) (
  input  logic [DATA_W-1:0] err,
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] res
);
  logic signed [PROD_W-1:0] prod, step;
  logic signed [PROD_W:0] diff;
  always_comb begin
    prod = $signed(err) * $signed(act);
    step = prod >>> SHIFT;
    diff = (PROD_W+1)'($signed(w)) - (PROD_W+1)'(step);
    res = diff > (PROD_W+1)'(Q_MAX) ? Q_MAX : diff < (PROD_W+1)'(Q_MIN) ? Q_MIN : diff[DATA_W-1:0];
  end
endmodule

// File: rtl/weight_update.sv
// weight_update: walks every output neuron, latches its error and rewrites its weights one per cycle.
module weight_update
  import weight_update_pkg::*;
#(
  parameter int N_OUT = 3,
  parameter int N_IN = 4,
  parameter int LR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_addr,
  input  logic [DATA_W-1:0] err_in,
  input  logic              act_wren,
  input  logic [1:0]        act_addr,
  input  logic [DATA_W-1:0] act_data,
  input  logic              w_wren,
  input  logic [3:0]        w_wraddr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [3:0]        w_rdaddr,
  output logic [DATA_W-1:0] w_rddata
);
  state_t state, next;
  logic [1:0] o, i;
  logic [DATA_W-1:0] err_reg, new_w;
  logic [DATA_W-1:0] act [4];
  logic [DATA_W-1:0] w [16];
  logic last_i, last_o;
  always_comb begin
    last_i = int'(i) == N_IN - 1;
    last_o = int'(o) == N_OUT - 1;
    next = state == IDLE ? (start ? LOAD_ERR : IDLE) :
           state == LOAD_ERR ? UPDATE :
           state == UPDATE ? (!last_i ? UPDATE : last_o ? DONE : LOAD_ERR) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    err_addr = busy ? o : 2'd0;
    w_rddata = below(w_rdaddr[3:2], N_OUT) && below(w_rdaddr[1:0], N_IN) ? w[w_rdaddr] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o <= '0;
      i <= '0;
      err_reg <= '0;
    end else if (state == LOAD_ERR) begin
      err_reg <= err_in;
      i <= '0;
    end else if (state == UPDATE) begin
      i <= last_i ? 2'd0 : i + 2'd1;
      o <= last_i && !last_o ? o + 2'd1 : o;
    end else begin
      o <= '0;
      i <= '0;
    end
  // External writes only land while idle; the update pass owns the RAM otherwise.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < 4; k++) act[k] <= '0;
      for (int k = 0; k < 16; k++) w[k] <= '0;
    end else if (state == UPDATE) begin
      w[{o, i}] <= new_w;
    end else if (!busy) begin
      if (act_wren && below(act_addr, N_IN)) act[act_addr] <= act_data;
      if (w_wren && below(w_wraddr[3:2], N_OUT) && below(w_wraddr[1:0], N_IN)) w[w_wraddr] <= w_data;
    end
  weight_update_fx_mac_sat #(.SHIFT(FRAC_BITS + LR_SHIFT)) mac (
    .err(err_reg),
    .act(act[i]),
    .w(w[{o, i}]),
    .res(new_w)
  );
endmodule

// File: tb/tb_weight_update.sv
// tb_weight_update: directed and random update passes checked against a real-arithmetic reference model.
module tb_weight_update;
  logic clk = 0, rst = 1, start = 0, act_wren = 0, w_wren = 0;
  logic busy, done;
  logic [1:0] err_addr, act_addr = 0;
  logic [15:0] err_in, act_data = 0, w_data = 0, w_rddata;
  logic [3:0] w_wraddr = 0, w_rdaddr = 0;
  logic [15:0] err_mem [4];
  logic [15:0] ma [4];
  logic [15:0] mw [16];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign err_in = err_mem[err_addr];
  weight_update dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err_addr(err_addr), .err_in(err_in),
    .act_wren(act_wren), .act_addr(act_addr), .act_data(act_data),
    .w_wren(w_wren), .w_wraddr(w_wraddr), .w_data(w_data),
    .w_rdaddr(w_rdaddr), .w_rddata(w_rddata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset;
    for (int k = 0; k < 4; k++) ma[k] = 0;
    for (int k = 0; k < 16; k++) mw[k] = 0;
  endtask
  function automatic logic [15:0] sat(input longint v);
    return v > 32767 ? 16'h7FFF : v < -32768 ? 16'h8000 : 16'(v);
  endfunction
  // Weight -= floor(err*act / 2^(10+2)), each operand taken as a signed Q6.10 integer.
  task automatic model_pass;
    for (int o = 0; o < 3; o++)
      for (int i = 0; i < 4; i++) begin
        longint p = longint'($signed(err_mem[o])) * longint'($signed(ma[i]));
        longint s = longint'($floor(real'(p) / 4096.0));
        mw[o*4+i] = sat(longint'($signed(mw[o*4+i])) - s);
      end
  endtask
  task automatic wr(input logic ae, input logic [1:0] aa, input logic [15:0] ad,
                    input logic we, input logic [3:0] wa, input logic [15:0] wd);
    @(negedge clk);
    act_wren = ae; act_addr = aa; act_data = ad;
    w_wren = we; w_wraddr = wa; w_data = wd;
    @(negedge clk);
    act_wren = 0; w_wren = 0;
    if (ae) ma[aa] = ad;
    if (we && wa[3:2] < 3) mw[wa] = wd;
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    w_rdaddr = a;
    #1;
    chk(tag, w_rddata, exp);
  endtask
  task automatic check_all(input string tag);
    for (int a = 0; a < 16; a++) rd_chk($sformatf("%s w[%0d]", tag, a), 4'(a), mw[a]);
  endtask
  task automatic run_pass(input bit collide, input bit abort);
    int cyc, ndone;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    ndone = 0;
    chk("busy_after_start", busy, 1);
    while (!done && cyc < 40) begin
      if (abort && cyc == 7) begin
        rst = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_err_addr", err_addr, 0);
        model_reset;
        @(negedge clk);
        rst = 0;
        return;
      end
      if (cyc == 11) chk("err_addr_o2", err_addr, 2);
      if (collide && cyc == 3) begin
        start = 1; w_wren = 1; w_wraddr = 4'h0; w_data = 16'h1234;
        act_wren = 1; act_addr = 2'd1; act_data = 16'h5555;
      end else begin
        start = 0; w_wren = 0; act_wren = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0; w_wren = 0; act_wren = 0;
    chk("done_cycle", cyc, 16);
    model_pass;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("done_pulse_width", done, 0);
    chk("start_in_done_ignored", busy, 0);
    repeat (20) @(negedge clk) ndone += int'(done);
    chk("done_once", ndone, 0);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) err_mem[k] = 0;
    model_reset;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err_addr", err_addr, 0);
    check_all("reset");
    wr(1, 2'd0, 16'h0400, 1, 4'h0, 16'h0000);
    wr(1, 2'd2, 16'h0800, 1, 4'h6, 16'h0100);
    wr(1, 2'd3, 16'h0400, 1, 4'hB, 16'h8010);
    err_mem[0] = 16'h0400; err_mem[1] = 16'hFC00; err_mem[2] = 16'h0400;
    run_pass(0, 0);
    rd_chk("basic", 4'h0, 16'hFF00);
    rd_chk("neg_err", 4'h6, 16'h0300);
    rd_chk("sat_neg", 4'hB, 16'h8000);
    check_all("pass1");
    wr(0, 2'd0, 16'h0, 1, 4'hB, 16'h7FF0);
    err_mem[2] = 16'hFC00;
    run_pass(0, 0);
    rd_chk("sat_pos", 4'hB, 16'h7FFF);
    check_all("pass2");
    wr(0, 2'd0, 16'h0, 1, 4'hD, 16'h7777);
    rd_chk("oor_read", 4'hD, 16'h0000);
    run_pass(1, 0);
    check_all("collide");
    run_pass(0, 1);
    chk("after_abort_busy", busy, 0);
    check_all("abort");
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 12; k++)
        wr(1, 2'(k % 4), 16'($urandom), 1, 4'(k), (p % 2) ? 16'($urandom) : 16'($urandom_range(0, 2047)));
      for (int k = 0; k < 3; k++)
        err_mem[k] = (p % 2) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
      run_pass(0, 0);
      check_all($sformatf("rand%0d", p));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
